uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 50: clk cycles between uart_load strobes (legal range 2..65535).
REQ-002 SHALL have parameter FRAME_TICKS, default 10: uart_load strobes per transmitted byte frame (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  each requester has a byte pending.
REQ-006 SHALL have ports req0_data / req1_data  input  8  byte offered by each requester.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  byte accepted when valid and ready are both high in the same cycle.
REQ-008 SHALL have port uart_data  output  8  byte presented to the UART_TX data input.
REQ-009 SHALL have port uart_send  output  1  drives the UART_TX send input.
REQ-010 SHALL have port uart_load  output  1  drives the UART_TX load input; one-cycle baud strobe.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port grant_id  output  1  requester that owns the current or last frame.

Function
REQ-013 SHALL run a free-running baud counter 0..CLKS_PER_BIT-1, with uart_load registered high for exactly one cycle every CLKS_PER_BIT cycles, independent of state.
REQ-014 SHALL implement states IDLE and SEND; busy = (state==SEND) and uart_send = (state==SEND).
REQ-015 SHALL drive both readies low outside IDLE; in IDLE, ready is combinational from the valids, so acceptance costs zero cycles.
REQ-016 In IDLE with exactly one valid high, SHALL assert only that requester's ready.
REQ-017 In IDLE with both valids high, SHALL assert the ready of the requester that did not win the previous grant (round robin); after reset, requester 0 wins first.
REQ-018 On an accept cycle, SHALL register the byte into uart_data, update grant_id and the round-robin pointer, clear the tick counter, and enter SEND on the next cycle.
REQ-019 SHALL hold uart_data stable throughout SEND and until the next accept.
REQ-020 In SEND, SHALL count uart_load strobes; the strobe on which the count equals FRAME_TICKS-1 is the last, and state returns to IDLE on the following cycle.
REQ-021 SHALL give a frame length in SEND of between (FRAME_TICKS-1)*CLKS_PER_BIT+1 and FRAME_TICKS*CLKS_PER_BIT cycles, depending on baud phase at acceptance.
REQ-022 SHALL NOT accept during the cycle SEND exits; a valid held high is accepted on the first IDLE cycle, giving one idle cycle between frames.
REQ-023 SHALL ignore a requester deasserting valid or changing data while not ready; SHALL never lose or duplicate an accepted byte.
REQ-024 SHALL size the tick counter at 4 bits and the baud counter at 16 bits; both wrap to 0 without overflow.

Reset
REQ-025 SHALL, on rst high at a clk edge, set state IDLE, the baud counter and tick counter to 0, uart_data to 8'h00, uart_send 0, uart_load 0, busy 0, grant_id 0, and the round-robin pointer to favour requester 0.
REQ-026 SHALL, on rst asserted mid-frame, abort the frame so that uart_send is low in the cycle after the reset edge; the aborted byte is not retransmitted.
REQ-027 SHALL keep both readies low while rst is high; the first uart_load follows CLKS_PER_BIT cycles after rst deasserts.

Configuration
REQ-028 SHALL recognise macro UART_TX_ARB_FIXED_PRIO_EN; when defined, requester 0 always wins simultaneous requests and the round-robin pointer is not implemented.
REQ-029 When UART_TX_ARB_FIXED_PRIO_EN is undefined, SHALL use the round-robin arbitration of REQ-017; single-requester behaviour is identical in both builds.

Verification
REQ-030 SHALL cover: defaults, req0_valid=1 with req0_data=8'h61 from IDLE -> req0_ready high that cycle, uart_data=8'h61 and busy=1 next cycle, busy held for 451..500 cycles, grant_id=0.
REQ-031 SHALL cover: req0 and req1 both valid continuously, data 8'hA0 and 8'hB1 -> uart_data sequence A0,B1,A0,B1 with grant_id alternating 0,1,0,1 and one idle cycle between frames.
REQ-032 SHALL cover: build with UART_TX_ARB_FIXED_PRIO_EN and both valid continuously -> every frame carries req0_data, req1_ready never high.
REQ-033 SHALL cover: rst pulsed one cycle at the 5th uart_load of a frame -> uart_send low next cycle, uart_data=8'h00, next uart_load exactly 50 cycles after rst drops.
REQ-034 SHALL cover: req1_valid high for one cycle only while busy -> no accept, no frame started for req1.
REQ-035 SHALL cover: no requests for 1000 cycles -> uart_load strobes exactly every 50 cycles, uart_send constantly 0.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Two-requester arbiter feeding a UART transmitter: free-running baud strobe, IDLE/SEND framing.
// Define UART_TX_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round robin.
module uart_tx_arb #(
  parameter int CLKS_PER_BIT = 50,
  parameter int FRAME_TICKS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic [7:0] uart_data,
  output logic       uart_send,
  output logic       uart_load,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  TICK_LAST = 4'(FRAME_TICKS - 1);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [3:0]  tick_cnt;
  logic        favor0;
  logic        accept;

  // Ready is combinational in IDLE so a waiting byte is taken with no extra cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && (!req1_valid || favor0)) req0_ready = 1'b1;
      else if (req1_valid)                       req1_ready = 1'b1;
    end
  end

  assign accept    = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  assign busy      = (state == SEND);
  assign uart_send = (state == SEND);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt  <= '0;
      uart_load <= 1'b0;
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt  <= '0;
      uart_load <= 1'b1;
    end else begin
      baud_cnt  <= baud_cnt + 16'd1;
      uart_load <= 1'b0;
    end
  end

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  assign favor0 = 1'b1;
`else
  // Tie goes to whichever requester did not win last time.
  always_ff @(posedge clk) begin
    if (rst)         favor0 <= 1'b1;
    else if (accept) favor0 <= req1_ready;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      uart_data <= 8'h00;
      grant_id  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            uart_data <= req1_ready ? req1_data : req0_data;
            grant_id  <= req1_ready;
            tick_cnt  <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          // A strobe landing on the accept cycle is not counted; only strobes seen in SEND are.
          if (uart_load) begin
            if (tick_cnt == TICK_LAST) state <= IDLE;
            else                       tick_cnt <= tick_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomised scoreboard bench for uart_tx_arb; the reference model works from cycle indices
// since the last reset edge and the arithmetic positions of baud strobes.
module tb_uart_tx_arb;

  localparam int CPB = 50;
  localparam int FT  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [7:0] uart_data;
  logic       uart_send, uart_load, busy, grant_id;

  uart_tx_arb #(.CLKS_PER_BIT(CPB), .FRAME_TICKS(FT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .uart_data  (uart_data),
    .uart_send  (uart_send),
    .uart_load  (uart_load),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       id;
    int         start;
    int         fin;
  } frame_t;

  frame_t exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  // Model state: k is the cycle index since the last reset edge.
  int k          = 0;
  bit rst_prev   = 1'b1;
  int send_start = -1;
  int send_end   = -1;
  bit favor0     = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model and per-cycle output checks, mid-cycle.
  always @(negedge clk) begin
    bit     exp_busy, exp_load, e0, e1;
    frame_t f;
    if (rst_prev) begin
      k = 0;
      send_start = -1;
      send_end = -1;
      favor0 = 1'b1;
    end else begin
      k++;
    end
    rst_prev = rst;

    exp_load = (k > 0) && (k % CPB == 0);
    exp_busy = (k >= send_start) && (k <= send_end);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst && !exp_busy) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      if (req0_valid) e0 = 1'b1;
`else
      if (req0_valid && (!req1_valid || favor0)) e0 = 1'b1;
`endif
      else if (req1_valid) e1 = 1'b1;
    end

    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("uart_load", uart_load, exp_load);
    check("uart_send", uart_send, exp_busy);
    if (k == 0) begin
      check("reset_uart_data", uart_data, 8'h00);
      check("reset_grant_id", grant_id, 1'b0);
      check("reset_busy", busy, 1'b0);
    end

    if (e0 || e1) begin
      f.data  = e1 ? req1_data : req0_data;
      f.id    = e1;
      f.start = k + 1;
      f.fin   = (k / CPB + FT) * CPB;
      exp_q.push_back(f);
      send_start = f.start;
      send_end   = f.fin;
      favor0     = e1;
    end
  end

  // Monitor: pops an expected frame whenever the DUT starts one.
  bit busy_prev = 1'b0;
  int cur_start = 0;
  int cur_end   = 0;
  always @(negedge clk) begin
    frame_t f;
    #2;
    if (busy === 1'b1 && !busy_prev) begin
      check("expected_frame_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        f = exp_q.pop_front();
        check("frame_data", uart_data, f.data);
        check("frame_grant_id", grant_id, f.id);
        check("frame_start_cycle", k, f.start);
        cur_start = f.start;
        cur_end   = f.fin;
      end
    end
    if (busy !== 1'b1 && busy_prev && k != 0) begin
      check("frame_end_cycle", k - 1, cur_end);
      check("frame_len_451_500", (k - cur_start >= (FT - 1) * CPB + 1) && (k - cur_start <= FT * CPB), 1'b1);
    end
    busy_prev = (busy === 1'b1);
  end

  initial begin
    int n_load;
    int budget;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = 8'h00;
    req1_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;

    // Quiet period: strobe spacing and idle outputs.
    repeat (1000) tick();

    // Single byte from requester 0.
    req0_valid = 1'b1;
    req0_data  = 8'h61;
    tick();
    req0_valid = 1'b0;
    req0_data  = 8'($urandom);
    repeat (520) tick();

    // Both requesters continuously: alternation from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 8'hA0;
    req1_valid = 1'b1;
    req1_data  = 8'hB1;
    repeat (2100) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (520) tick();

    // Reset pulse on the 5th strobe of a frame.
    req0_valid = 1'b1;
    req0_data  = 8'h3C;
    tick();
    req0_valid = 1'b0;
    n_load = 0;
    budget = 0;
    while (n_load < 5 && budget < 1000) begin
      if (uart_load === 1'b1) n_load++;
      if (n_load < 5) tick();
      budget++;
    end
    check("fifth_strobe_seen", n_load, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (120) tick();

    // A one-cycle request from requester 1 while busy must be dropped.
    req0_valid = 1'b1;
    req0_data  = 8'h5A;
    tick();
    req0_valid = 1'b0;
    repeat (100) tick();
    req1_valid = 1'b1;
    req1_data  = 8'hC3;
    tick();
    req1_valid = 1'b0;
    repeat (520) tick();

    // Random valids and data, changing freely while not ready.
    for (int i = 0; i < 6000; i++) begin
      req0_valid = ($urandom_range(0, 2) == 0);
      req1_valid = ($urandom_range(0, 2) == 0);
      req0_data  = 8'($urandom);
      req1_data  = 8'($urandom);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (520) tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
